load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum number of cycles spent waiting for mem_ready (used only with LSU_TIMEOUT_EN).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin an access; sampled only in IDLE.
REQ-006 is_store  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 base  input  32  rs1 value from the register file.
REQ-009 offset  input  32  sign-extended immediate.
REQ-010 store_data  input  32  rs2 value from the register file.
REQ-011 rd_in  input  5  load destination register.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 fault  output  1  qualifies done; the access was aborted.
REQ-015 fault_code  output  2  01 misaligned, 10 illegal funct3, 11 timeout.
REQ-016 wb_we  output  1  register-file write enable.
REQ-017 wb_rd  output  5  register-file write address.
REQ-018 wb_data  output  32  register-file write data.
REQ-019 mem_req  output  1  memory request; held high until accepted.
REQ-020 mem_we  output  1  1 = memory write.
REQ-021 mem_addr  output  32  word-aligned address; bits [1:0] always 00.
REQ-022 mem_wdata  output  32  lane-replicated store data.
REQ-023 mem_wstrb  output  4  byte-write strobes; 0000 for loads.
REQ-024 mem_ready  input  1  memory accepts the request (and returns read data) in this cycle.
REQ-025 mem_rdata  input  32  read data, valid when mem_ready is high during a load.

Function
REQ-026 SHALL implement the FSM IDLE -> REQ -> DONE -> IDLE; start with a fault condition SHALL go IDLE -> DONE directly.
REQ-027 SHALL, on start in IDLE, register eff = base + offset (mod 2^32) together with is_store, funct3, store_data and rd_in.
REQ-028 SHALL flag misaligned for a halfword with eff[0]=1 or a word with eff[1:0]!=0, and illegal for load funct3 of 3/6/7 or store funct3 of 3-7; illegal takes priority over misaligned.
REQ-029 SHALL, in REQ, drive mem_req=1 with mem_addr, mem_we, mem_wdata and mem_wstrb stable, and move to DONE on the first cycle in which mem_ready=1, capturing mem_rdata for loads.
REQ-030 SHALL set latency: start at cycle N gives mem_req at N+1; mem_ready at cycle M>=N+1 gives done at M+1; a faulting start gives done+fault at N+1 with mem_req never asserted.
REQ-031 SHALL, for stores, drive SB as {4{byte}} with strobe 0001<<eff[1:0], SH as {2{half}} with strobe 0011<<eff[1:0], and SW as the full word with strobe 1111.
REQ-032 SHALL, for loads, select the lane by eff[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-033 SHALL, in DONE, pulse done and assert wb_we only for a non-faulting load with rd_in!=0, with wb_rd/wb_data valid in that cycle; wb_we, wb_rd and wb_data SHALL be 0 in all other cycles.
REQ-034 SHALL ignore start while busy is high, including the DONE cycle.

Reset
REQ-035 SHALL, on reset low, go to IDLE immediately (asynchronously), mid-access included, driving every output to 0 and abandoning any outstanding request.
REQ-036 SHALL discard any mem_ready that arrives after an abandoning reset.

Configuration
REQ-037 SHALL, with LSU_TIMEOUT_EN defined, count cycles in REQ and, when the count reaches TIMEOUT_CYCLES, drop mem_req, go to DONE, and raise fault with fault_code=11.
REQ-038 SHALL, without LSU_TIMEOUT_EN, wait in REQ indefinitely, with no counter logic instantiated.

Structure
REQ-039 SHALL place the funct3 constants, the state encoding and the fault_code values in the package lsu_pkg.
REQ-040 SHALL put the combinational lane extract/insert logic in the sub-module lsu_align.

Verification
REQ-041 SB: base=0x100, offset=3, rs2=0xA5 -> mem_addr=0x100, wstrb=1000, wdata=0xA5A5A5A5, done 1 cycle after mem_ready, wb_we=0.
REQ-042 LB: eff=0x202, mem_rdata=0x00800000, rd=5 -> wb_data=0xFFFFFF80; LBU gives 0x00000080; wb_we=1, wb_rd=5.
REQ-043 LW: eff=0x1002 -> done+fault, fault_code=01, at the next cycle; mem_req never high.
REQ-044 LW with rd=0 and mem_ready delayed 5 cycles -> mem_req held high 5 cycles, done with wb_we=0; start pulsed while busy is ignored.
REQ-045 Reset low while in REQ -> mem_req=0 the same cycle; a later mem_ready produces no done.
REQ-046 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready never asserted -> done+fault, fault_code=11, after 4 REQ cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and fault codes for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_MISALIGN = 2'b01;
    localparam logic [1:0] FC_ILLEGAL  = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

    // Illegal encodings win over misalignment so a bad funct3 is never reported as an alignment issue.
    function automatic logic [1:0] check_access(input logic is_store, input logic [2:0] f3,
                                                input logic [1:0] lane);
        logic illegal;
        logic misalign;
        illegal  = is_store ? (f3 > F3_W) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        misalign = (f3[1:0] == 2'b01 && lane[0]) || (f3[1:0] == 2'b10 && lane != 2'b00);
        if (illegal)       return FC_ILLEGAL;
        else if (misalign) return FC_MISALIGN;
        else               return FC_NONE;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane insert for stores and lane extract/extend for loads
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_lane,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        st_wdata = st_data;
        st_wstrb = 4'b1111;
        case (st_funct3[1:0])
            2'b00: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_lane;
            end
            2'b01: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = 4'b0011 << st_lane;
            end
            default: begin
                st_wdata = st_data;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        shifted = ld_rdata >> {ld_lane, 3'b000};
        case (ld_funct3)
            F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ld_data = {24'd0, shifted[7:0]};
            F3_HU:   ld_data = {16'd0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store sequencer; optional REQ timeout under LSU_TIMEOUT_EN
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    lsu_state_e  state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lane_q, lane_d;
    logic [4:0]  rd_q, rd_d;
    logic        busy_q, busy_d, done_q, done_d, fault_q, fault_d;
    logic [1:0]  fault_code_q, fault_code_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;

    logic [31:0] eff;
    logic [1:0]  start_fc;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_wstrb;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    assign eff      = base + offset;
    assign start_fc = check_access(is_store, funct3, eff[1:0]);

    lsu_align u_align (
        .st_funct3 (funct3),
        .st_lane   (eff[1:0]),
        .st_data   (store_data),
        .st_wdata  (st_wdata),
        .st_wstrb  (st_wstrb),
        .ld_funct3 (funct3_q),
        .ld_lane   (lane_q),
        .ld_rdata  (mem_rdata),
        .ld_data   (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        rd_d         = rd_q;
        done_d       = 1'b0;
        fault_d      = 1'b0;
        fault_code_d = FC_NONE;
        wb_we_d      = 1'b0;
        wb_rd_d      = 5'd0;
        wb_data_d    = 32'd0;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = 32'd0;
        mem_wdata_d  = 32'd0;
        mem_wstrb_d  = 4'd0;
`ifdef LSU_TIMEOUT_EN
        cnt_d        = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    lane_d     = eff[1:0];
                    rd_d       = rd_in;
                    if (start_fc != FC_NONE) begin
                        state_d      = ST_DONE;
                        done_d       = 1'b1;
                        fault_d      = 1'b1;
                        fault_code_d = start_fc;
                    end else begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {eff[31:2], 2'b00};
                        mem_wdata_d = is_store ? st_wdata : 32'd0;
                        mem_wstrb_d = is_store ? st_wstrb : 4'd0;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (!is_store_q && rd_q != 5'd0) begin
                        wb_we_d   = 1'b1;
                        wb_rd_d   = rd_q;
                        wb_data_d = ld_data;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = ST_DONE;
                    done_d       = 1'b1;
                    fault_d      = 1'b1;
                    fault_code_d = FC_TIMEOUT;
`endif
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_we_q;
                    mem_addr_d  = mem_addr_q;
                    mem_wdata_d = mem_wdata_q;
                    mem_wstrb_d = mem_wstrb_q;
`ifdef LSU_TIMEOUT_EN
                    cnt_d       = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'd0;
            lane_q       <= 2'd0;
            rd_q         <= 5'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_wstrb_q  <= 4'd0;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            rd_q         <= rd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule
